// File: rtl/formula_pkg.sv
// Shared types and defaults for the formula argument path.
// The pacer and its FIFO take their widths and default parameters from here.
package formula_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } formula_args_t;

    localparam int unsigned FORMULA_ISQRT_LATENCY = 16;
    localparam int unsigned FORMULA_ARG_DEPTH     = 4;
    localparam int unsigned FORMULA_ARGS_W        = $bits(formula_args_t);

    // The downstream FSM re-arms N+3 cycles after accepting a triple.
    function automatic int unsigned issue_gap(input int unsigned isqrt_latency);
        return isqrt_latency + 3;
    endfunction

endpackage

// File: rtl/formula_arg_fifo.sv
// Generic circular FIFO with a registered occupancy count.
// The head entry is always visible; push and pop are ignored when full or empty.
module formula_arg_fifo
    import formula_pkg::*;
#(
    parameter int unsigned WIDTH = FORMULA_ARGS_W,
    parameter int unsigned DEPTH = FORMULA_ARG_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q];

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/formula_1_arg_pacer.sv
// Rate matcher in front of formula_1_pipe_aware_fsm: buffers producer triples
// and issues them as single-cycle pulses no closer than GAP cycles apart.
module formula_1_arg_pacer
    import formula_pkg::*;
#(
    parameter int unsigned ISQRT_LATENCY = FORMULA_ISQRT_LATENCY,
    parameter int unsigned DEPTH         = FORMULA_ARG_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        up_vld,
    output logic        up_rdy,
    input  logic [31:0] up_a,
    input  logic [31:0] up_b,
    input  logic [31:0] up_c,
    output logic        arg_vld,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] c
);

    localparam int unsigned GAP   = issue_gap(ISQRT_LATENCY);
    localparam int unsigned GAP_W = $clog2(GAP);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

    formula_args_t    up_args;
    formula_args_t    head_args;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    assign up_args = '{a: up_a, b: up_b, c: up_c};

    // No same-cycle refill when full: readiness ignores a concurrent pop.
    assign up_rdy = !full && !rst;
    assign push   = up_vld && up_rdy;

    assign arg_vld = !empty && (gap_cnt_q == '0);
    assign pop     = arg_vld;

    assign a = head_args.a;
    assign b = head_args.b;
    assign c = head_args.c;

    formula_arg_fifo #(
        .WIDTH ($bits(formula_args_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (up_args),
        .pop     (pop),
        .head    (head_args),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (arg_vld) begin
            gap_cnt_d = GAP_LOAD;
        end else if (gap_cnt_q != '0) begin
            gap_cnt_d = gap_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

endmodule

// File: tb/tb_formula_1_arg_pacer.sv
// Directed bench for formula_1_arg_pacer with ISQRT_LATENCY=16 (GAP=19), DEPTH=4.
module tb_formula_1_arg_pacer;

    localparam int GAP = 19;

    logic        clk = 1'b0;
    logic        rst;
    logic        up_vld;
    logic        up_rdy;
    logic [31:0] up_a, up_b, up_c;
    logic        arg_vld;
    logic [31:0] a, b, c;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    int          iss_cyc [$];
    logic [95:0] iss_dat [$];
    int          acc_cyc [$];
    logic [95:0] acc_dat [$];

    formula_1_arg_pacer #(
        .ISQRT_LATENCY (16),
        .DEPTH         (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .up_vld  (up_vld),
        .up_rdy  (up_rdy),
        .up_a    (up_a),
        .up_b    (up_b),
        .up_c    (up_c),
        .arg_vld (arg_vld),
        .a       (a),
        .b       (b),
        .c       (c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && arg_vld) begin
            iss_cyc.push_back(cyc);
            iss_dat.push_back({a, b, c});
        end
    end

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dat(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        iss_cyc.delete();
        iss_dat.delete();
        acc_cyc.delete();
        acc_dat.delete();
    endtask

    // Called at posedge+1; holds up_vld until n triples are accepted.
    task automatic stream(input int n, input int base, input int budget);
        int i = 0;
        int t = 0;
        while (i < n && t < budget) begin
            up_vld = 1'b1;
            up_a   = base + 3 * i;
            up_b   = base + 3 * i + 1;
            up_c   = base + 3 * i + 2;
            #1;
            if (up_rdy) begin
                acc_cyc.push_back(cyc);
                acc_dat.push_back({up_a, up_b, up_c});
                i++;
            end
            tick();
            t++;
        end
        up_vld = 1'b0;
        chk_int("stream_accepted", i, n);
    endtask

    task automatic wait_issues(input int n, input int budget);
        int t = 0;
        while (iss_cyc.size() < n && t < budget) begin
            tick();
            t++;
        end
        repeat (GAP + 2) tick();
        chk_int("issue_count", iss_cyc.size(), n);
    endtask

    initial begin
        int s;
        int r;
        int held;
        int got;
        int ok;

        rst    = 1'b1;
        up_vld = 1'b0;
        up_a   = '0;
        up_b   = '0;
        up_c   = '0;
        repeat (3) tick();
        chk_int("reset_up_rdy", int'(up_rdy), 0);
        chk_int("reset_arg_vld", int'(arg_vld), 0);
        rst = 1'b0;
        #1;
        chk_int("post_reset_up_rdy", int'(up_rdy), 1);
        chk_int("post_reset_arg_vld", int'(arg_vld), 0);
        tick();

        // Single triple: issue one cycle after the push, exactly once.
        clear_logs();
        s = cyc;
        up_vld = 1'b1;
        up_a = 32'd1;
        up_b = 32'd4;
        up_c = 32'd9;
        #1;
        chk_int("single_up_rdy", int'(up_rdy), 1);
        tick();
        up_vld = 1'b0;
        wait_issues(1, 10);
        chk_int("single_cycle", iss_cyc[0], s + 1);
        chk_dat("single_data", iss_dat[0], {32'd1, 32'd4, 32'd9});

        // Late arrival: push 5 cycles after an issue waits for the gap.
        clear_logs();
        s = cyc;
        stream(1, 100, 5);
        while (cyc < s + 6) tick();
        stream(1, 200, 5);
        wait_issues(2, 40);
        chk_int("late_first", iss_cyc[0], s + 1);
        chk_int("late_second", iss_cyc[1], s + 20);
        chk_dat("late_data", iss_dat[1], {32'd200, 32'd201, 32'd202});

        // Burst with backpressure.
        clear_logs();
        s = cyc;
        stream(6, 1000, 60);
        chk_int("burst_acc0", acc_cyc[0], s);
        chk_int("burst_acc4", acc_cyc[4], s + 4);
        chk_int("burst_acc5", acc_cyc[5], s + 21);
        wait_issues(6, 200);
        for (int k = 0; k < 6; k++) begin
            chk_int($sformatf("burst_issue_cyc%0d", k), iss_cyc[k], s + 1 + GAP * k);
            chk_dat($sformatf("burst_issue_dat%0d", k), iss_dat[k], acc_dat[k]);
        end

        // Wrap-around: 20 triples through the 4-entry ring.
        clear_logs();
        s = cyc;
        stream(20, 5000, 500);
        wait_issues(20, 500);
        chk_int("wrap_first_cyc", iss_cyc[0], s + 1);
        for (int k = 0; k < 20; k++) begin
            chk_dat($sformatf("wrap_dat%0d", k), iss_dat[k], acc_dat[k]);
            if (k > 0) begin
                chk_int($sformatf("wrap_gap%0d", k), iss_cyc[k] - iss_cyc[k - 1], GAP);
            end
        end

        // Reset mid-burst with 3 queued and gap_cnt at 7.
        clear_logs();
        s = cyc;
        stream(4, 9000, 10);
        while (cyc < s + 13) tick();
        r = cyc;
        rst = 1'b1;
        #1;
        chk_int("midrst_up_rdy", int'(up_rdy), 0);
        tick();
        rst = 1'b0;
        #1;
        chk_int("midrst_arg_vld", int'(arg_vld), 0);
        chk_int("midrst_up_rdy_after", int'(up_rdy), 1);
        stream(1, 7000, 5);
        wait_issues(2, 40);
        chk_int("midrst_first", iss_cyc[0], s + 1);
        chk_int("midrst_new_cyc", iss_cyc[1], r + 2);
        chk_dat("midrst_new_dat", iss_dat[1], {32'd7000, 32'd7001, 32'd7002});

        // Random 30% producer against a scoreboard.
        clear_logs();
        held = 0;
        got  = 0;
        for (int t = 0; t < 3000 && got < 30; t++) begin
            if (held == 0 && $urandom_range(0, 99) < 30) begin
                held = 1;
                up_a = $urandom;
                up_b = $urandom;
                up_c = $urandom;
            end
            up_vld = (held != 0);
            #1;
            if (held != 0 && up_rdy) begin
                acc_cyc.push_back(cyc);
                acc_dat.push_back({up_a, up_b, up_c});
                held = 0;
                got++;
            end
            tick();
        end
        up_vld = 1'b0;
        chk_int("rand_accepted", got, 30);
        wait_issues(got, 1000);
        ok = 1;
        for (int k = 0; k < iss_dat.size() && k < acc_dat.size(); k++) begin
            if (iss_dat[k] !== acc_dat[k]) ok = 0;
            if (k > 0 && iss_cyc[k] - iss_cyc[k - 1] < GAP) ok = 0;
        end
        chk_int("rand_order_and_gap", ok, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/formula_1_arg_pacer.md
# formula_1_arg_pacer

Upstream rate-matching stage for `formula_1_pipe_aware_fsm`. It accepts argument triples (a, b, c) from a valid/ready producer at up to one per cycle and buffers them in a small FIFO. It then issues them to the FSM as single-cycle `arg_vld` pulses spaced at least N+3 cycles apart, which is the FSM's guaranteed acceptance interval. Without this stage, a producer that bursts would violate the FSM's non-pipelined input contract and lose triples.

## Interface
- `ISQRT_LATENCY`, default 16: N, the pipeline depth of the downstream `isqrt`.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥2.
- Derived localparam `GAP` = `ISQRT_LATENCY` + 3: minimum cycles between consecutive `arg_vld` pulses.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `up_vld`  in  1  producer triple valid.
- `up_rdy`  out  1  pacer can accept; equals `!full && !rst`.
- `up_a`, `up_b`, `up_c`  in  32 each  producer arguments.
- `arg_vld`  out  1  one-cycle issue pulse to the FSM.
- `a`, `b`, `c`  out  32 each  issued arguments; meaningful only while `arg_vld` is high.

## Operation
- **Push:** occurs when `up_vld && up_rdy`. The triple is written at `wr_ptr`, and `wr_ptr` increments and wraps modulo `DEPTH`.
- **Gap counter `gap_cnt`:**
  - Width is `$clog2(GAP)`; reset value 0.
  - Decrements each cycle while nonzero.
  - Loads `GAP`-1 in any cycle where `arg_vld` is high.
- **Issue:**
  - `arg_vld` = `!empty && gap_cnt == 0`.
  - It is combinational from registers only and has no input-to-output path.
  - `a`, `b`, `c` are driven from the FIFO head. An issue cycle pops the head and increments `rd_ptr`.
- **Occupancy:**
  - `count` ranges 0..`DEPTH`.
  - `full` = `count == DEPTH`; `empty` = `count == 0`.
  - Push and pop in the same cycle leave `count` unchanged.
- **Boundary rules:**
  - Full: `up_rdy` = 0 even if a pop happens in the same cycle (no same-cycle refill). The producer must hold its data.
  - Empty with `gap_cnt == 0`: a triple pushed at edge t issues in cycle t+1, so latency is 1 cycle.
  - Empty with `gap_cnt > 0`: the triple waits until `gap_cnt` reaches 0, then issues in that same cycle.
  - Pointer wrap: the FIFO uses `DEPTH`-entry circular storage, and `count` distinguishes full from empty.
  - Reset mid-operation:
    - FIFO contents are discarded: pointers, `count` and `gap_cnt` go to 0.
    - `arg_vld` goes to 0 in the cycle after the reset edge.
    - The first post-reset triple may issue immediately; no gap is carried across reset.
- **Output values:** `a`, `b`, `c` while `arg_vld` = 0 are don't-care. The bench checks them only when `arg_vld` is high.
- **Arithmetic:** no data arithmetic; data passes through bit-exact.

## Timing
- **Reset values:**
  - `arg_vld` = 0.
  - `up_rdy` = 0 while `rst` is high, and 1 in the first cycle after `rst` falls.
  - `a`/`b`/`c` are undefined; storage is not reset.
- **Issue spacing:** the issue-to-issue interval is exactly `GAP` cycles while the FIFO stays nonempty, and ≥`GAP` otherwise.
- **Throughput:** sustained one triple per `GAP` cycles.
- **Burst absorption:** the producer can burst `DEPTH`+1 triples at one per cycle before the first `up_rdy` deassertion, because one triple drains on cycle 1.
- **FSM contract:** the downstream FSM must be in its load-a state whenever `arg_vld` is high. `GAP` guarantees this for an FSM that accepts every N+3 cycles.

## Structure
- **Package `formula_pkg`:**
  - `typedef struct packed { logic [31:0] a, b, c; } formula_args_t;`
  - `localparam` for default `ISQRT_LATENCY`.
- **Sub-module `formula_arg_fifo`:**
  - Generic width/depth circular FIFO with `push`, `pop`, `full`, `empty` and `head`.
  - The pacer instantiates it once with the `formula_args_t` width and adds the gap counter and issue logic.
- **Top-level wiring:** the pacer sits in front of `formula_1_pipe_aware_fsm` inside the formula top. `arg_vld`/`a`/`b`/`c` connect directly to the FSM.

## Test plan
All scenarios use `ISQRT_LATENCY`=16 (`GAP`=19) and `DEPTH`=4.

- **Single triple:** push (1,4,9) at cycle 5 → `arg_vld` high in cycle 6 only, with `a`=1, `b`=4, `c`=9. With the FSM attached, the top result is 6.
- **Burst with backpressure:** hold `up_vld` with 6 distinct triples from cycle 0.
  - Expect 5 accepted by cycle 4 and `up_rdy` = 0 at cycle 5.
  - The 6th is accepted at the cycle after the second issue.
  - Issues occur at cycles 1, 20, 39, 58, 77, 96, in order.
- **Late arrival:** issue at cycle 10, next push at cycle 15 → issue at cycle 29, not 16.
- **Wrap-around:** stream 20 triples with `up_vld` held → all 20 issued in order, all spaced exactly 19 cycles, data bit-exact through pointer wrap.
- **Reset mid-burst:** assert `rst` with 3 triples queued and `gap_cnt` = 7.
  - After reset, expect no stale issue.
  - A new push at cycle r+1 issues at cycle r+2.
- **Random stress:** random `up_vld` at 30% against a scoreboard.
  - No loss or reordering.
  - No two `arg_vld` pulses less than 19 cycles apart.
